// File: rtl/fir_seq_mac.sv
`default_nettype none
// ============================================================================
// Module   : fir_seq_mac
// Purpose  : Sequential FIR MAC; accumulates one burst of N_TAPS samples
//            against ROM coefficients and emits one filtered sample.
//            Optional macro FIR_SAT_EN selects a saturating output.
// Revision : 1.0 - initial release
// ============================================================================
module fir_seq_mac #(
    parameter int N_TAPS = 1021,
    parameter int DW     = 16,
    parameter int AW     = 42,
    parameter int FRAC   = 15,
    localparam int CW    = $clog2(N_TAPS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sequencing,
    input  logic signed [DW-1:0] smpl_in,
    output logic [CW-1:0]        coeff_addr,
    input  logic signed [DW-1:0] coeff,
    output logic [DW-1:0]        filt_out,
    output logic                 filt_vld,
    output logic                 tap_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_taps       = CW'(N_TAPS);
    localparam logic [1:0]    c_drain_last = 2'd2;

    state_t                 state_q, state_d;
    logic [CW-1:0]          tap_cnt_q, tap_cnt_d;
    logic [1:0]             drain_cnt_q, drain_cnt_d;
    logic                   ovr_q, ovr_d;
    logic                   err_q, err_d;
    logic                   w_accept;
    logic                   w_valid;
    logic                   w_fire;

    logic signed [DW-1:0]   smpl_a_q;
    logic                   va_q, fa_q;
    logic signed [2*DW-1:0] prod_q;
    logic                   vb_q, fb_q;
    logic signed [AW-1:0]   acc_q;
    logic signed [AW-1:0]   w_prod_ext;
    logic [DW-1:0]          w_out;
    logic [DW-1:0]          filt_out_q;
    logic                   filt_vld_q;
    logic                   tap_err_q;

    always_comb begin
        state_d     = state_q;
        tap_cnt_d   = tap_cnt_q;
        drain_cnt_d = drain_cnt_q;
        ovr_d       = ovr_q;
        err_d       = err_q;
        w_accept    = 1'b0;
        w_fire      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sequencing) begin
                    w_accept = 1'b1;
                    state_d  = ST_MAC;
                end
            end
            ST_MAC: begin
                if (sequencing) begin
                    w_accept = 1'b1;
                end else begin
                    // Burst closed: latch its error status and rearm the counters.
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 2'd0;
                    tap_cnt_d   = '0;
                    ovr_d       = 1'b0;
                    err_d       = ovr_q || (tap_cnt_q != c_taps);
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == c_drain_last) begin
                    state_d = ST_IDLE;
                    w_fire  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (w_accept) begin
            if (tap_cnt_q == c_taps) begin
                ovr_d = 1'b1;
            end else begin
                tap_cnt_d = tap_cnt_q + 1'b1;
            end
        end
    end

    assign w_valid    = w_accept && (tap_cnt_q != c_taps);
    assign w_prod_ext = {{(AW-2*DW){prod_q[2*DW-1]}}, prod_q};

`ifdef FIR_SAT_EN
    // Bits above the output window must all match the sign for an in-range result.
    logic [AW-FRAC-DW:0] w_hi;
    assign w_hi = acc_q[AW-1:FRAC+DW-1];
    always_comb begin
        w_out = acc_q[FRAC+DW-1:FRAC];
        if (!acc_q[AW-1] && (w_hi != '0)) begin
            w_out = {1'b0, {(DW-1){1'b1}}};
        end else if (acc_q[AW-1] && (w_hi != '1)) begin
            w_out = {1'b1, {(DW-1){1'b0}}};
        end
    end
`else
    assign w_out = acc_q[FRAC+DW-1:FRAC];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tap_cnt_q   <= '0;
            drain_cnt_q <= 2'd0;
            ovr_q       <= 1'b0;
            err_q       <= 1'b0;
            smpl_a_q    <= '0;
            va_q        <= 1'b0;
            fa_q        <= 1'b0;
            prod_q      <= '0;
            vb_q        <= 1'b0;
            fb_q        <= 1'b0;
            acc_q       <= '0;
            filt_out_q  <= '0;
            filt_vld_q  <= 1'b0;
            tap_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_cnt_q   <= tap_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            ovr_q       <= ovr_d;
            err_q       <= err_d;
            smpl_a_q    <= smpl_in;
            va_q        <= w_valid;
            fa_q        <= (tap_cnt_q == '0);
            prod_q      <= smpl_a_q * coeff;
            vb_q        <= va_q;
            fb_q        <= fa_q;
            if (vb_q) begin
                acc_q <= fb_q ? w_prod_ext : acc_q + w_prod_ext;
            end
            filt_vld_q <= w_fire;
            tap_err_q  <= w_fire && err_q;
            if (w_fire) begin
                filt_out_q <= w_out;
            end
        end
    end

    assign coeff_addr = tap_cnt_q;
    assign filt_out   = filt_out_q;
    assign filt_vld   = filt_vld_q;
    assign tap_err    = tap_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fir_seq_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_seq_mac
// Purpose  : Self-checking bench for fir_seq_mac with a burst-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_seq_mac;

    localparam int N = 1021;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               sequencing;
    logic signed [15:0] smpl_in;
    logic [9:0]         coeff_addr;
    logic signed [15:0] coeff;
    logic [15:0]        filt_out;
    logic               filt_vld;
    logic               tap_err;
    logic               busy;

    logic signed [15:0] rom [0:1023];
    logic signed [15:0] smpls [$];
    logic [15:0]        last_out;
    int                 n_chk  = 0;
    int                 n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) coeff <= rom[coeff_addr];

    fir_seq_mac dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sequencing (sequencing),
        .smpl_in    (smpl_in),
        .coeff_addr (coeff_addr),
        .coeff      (coeff),
        .filt_out   (filt_out),
        .filt_vld   (filt_vld),
        .tap_err    (tap_err),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Result of one burst: dot product of the first N samples with the ROM.
    function automatic void model(output logic [15:0] o, output logic e);
        longint acc = 0;
        longint sh;
        for (int k = 0; k < smpls.size() && k < N; k++) begin
            acc += longint'(smpls[k]) * longint'(rom[k]);
        end
        sh = acc >>> 15;
`ifdef FIR_SAT_EN
        if (sh > 32767)       o = 16'h7FFF;
        else if (sh < -32768) o = 16'h8000;
        else                  o = sh[15:0];
`else
        o = sh[15:0];
`endif
        e = (smpls.size() != N);
    endfunction

    task automatic fill_rom(input int mode, input logic [15:0] val);
        for (int k = 0; k < 1024; k++) begin
            rom[k] = (mode == 0) ? val : 16'($urandom);
        end
    endtask

    // mode 0: constant val, 1: sample = index, 2: random
    task automatic run_burst(input int len, input int mode, input logic [15:0] val,
                             input bit use_const, input logic [15:0] const_out);
        logic [15:0] eo;
        logic        ee;
        smpls.delete();
        for (int k = 0; k < len; k++) begin
            smpls.push_back((mode == 0) ? val : (mode == 1) ? 16'(k) : 16'($urandom));
        end
        for (int k = 0; k < len; k++) begin
            check("coeff_addr", coeff_addr, (k < N) ? k : N);
            sequencing = 1'b1;
            smpl_in    = smpls[k];
            @(posedge clk); #1;
        end
        sequencing = 1'b0;
        smpl_in    = 16'($urandom);
        model(eo, ee);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            check("filt_vld", filt_vld, (i == 4));
            check("busy", busy, (i != 4));
            if (i < 4) check("tap_err_early", tap_err, 1'b0);
        end
        check("filt_out", filt_out, eo);
        check("tap_err", tap_err, ee);
        if (use_const) check("filt_out_const", filt_out, const_out);
        last_out = eo;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle_vld", filt_vld, 1'b0);
            check("idle_err", tap_err, 1'b0);
            check("idle_busy", busy, 1'b0);
            check("hold_out", filt_out, last_out);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        sequencing = 1'b0;
        smpl_in    = '0;
        last_out   = '0;
        fill_rom(0, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_out", filt_out, 16'h0000);
        check("rst_vld", filt_vld, 1'b0);
        check("rst_err", tap_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_addr", coeff_addr, 10'd0);
        idle(2);

        fill_rom(0, 16'h7FFF);
        run_burst(N, 0, 16'h0001, 1'b1, 16'h03FC);
        idle(3);

        fill_rom(0, 16'h0000);
        rom[5] = 16'h4000;
        run_burst(N, 1, 16'h0000, 1'b1, 16'h0002);
        idle(2);

        fill_rom(0, 16'h7FFF);
        run_burst(1000, 0, 16'h1000, 1'b0, 16'h0000);
        idle(2);
        run_burst(N, 0, 16'h7FFF, 1'b0, 16'h0000);
        idle(1);
        run_burst(N, 0, 16'h8000, 1'b0, 16'h0000);
        idle(1);

        fill_rom(1, 16'h0000);
        run_burst(1, 2, 16'h0000, 1'b0, 16'h0000);
        idle(1);
        run_burst(N + 4, 2, 16'h0000, 1'b0, 16'h0000);
        idle(1);

        // Abort a burst with a one-cycle reset at tap 500.
        for (int k = 0; k < 500; k++) begin
            sequencing = 1'b1;
            smpl_in    = 16'($urandom);
            @(posedge clk); #1;
        end
        rst_n      = 1'b0;
        sequencing = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", busy, 1'b0);
        check("abort_addr", coeff_addr, 10'd0);
        last_out = 16'h0000;
        idle(8);
        run_burst(N, 2, 16'h0000, 1'b0, 16'h0000);

        // Back-to-back bursts with the minimum gap.
        run_burst(N, 2, 16'h0000, 1'b0, 16'h0000);
        run_burst(N, 2, 16'h0000, 1'b0, 16'h0000);
        idle(2);

        for (int r = 0; r < 6; r++) begin
            int len;
            fill_rom(1, 16'h0000);
            case ($urandom_range(0, 3))
                0:       len = N;
                1:       len = $urandom_range(1, N - 1);
                2:       len = N + $urandom_range(1, 8);
                default: len = $urandom_range(1, 4);
            endcase
            run_burst(len, 2, 16'h0000, 1'b0, 16'h0000);
            idle($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
